// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment order {a,b,c,d,e,f,g} = bits 6..0, active-low codes.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } frame_state_e;

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational inverse of the nibble encoder: 7-bit active-low pattern -> nibble + illegal flag.
module seg_pattern_dec
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] i_pat,
  output logic [NIB_W-1:0] o_val_c,
  output logic             o_err_c
);

  always_comb begin
    o_val_c = '0;
    o_err_c = 1'b0;
    case (i_pat)
      SEG_0:   o_val_c = 4'h0;
      SEG_1:   o_val_c = 4'h1;
      SEG_2:   o_val_c = 4'h2;
      SEG_3:   o_val_c = 4'h3;
      SEG_4:   o_val_c = 4'h4;
      SEG_5:   o_val_c = 4'h5;
      SEG_6:   o_val_c = 4'h6;
      SEG_7:   o_val_c = 4'h7;
      SEG_8:   o_val_c = 4'h8;
      SEG_9:   o_val_c = 4'h9;
      SEG_A:   o_val_c = 4'hA;
      SEG_B:   o_val_c = 4'hB;
      SEG_C:   o_val_c = 4'hC;
      SEG_D:   o_val_c = 4'hD;
      SEG_E:   o_val_c = 4'hE;
      SEG_F:   o_val_c = 4'hF;
      default: o_err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment bus monitor: debounces each digit, decodes it and
// hands out one complete frame per scan over a valid/ready handshake.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter  int unsigned NDIG       = 8,
  parameter  int unsigned STABLE_CYC = 4,
  localparam int unsigned CNT_W      = $clog2(STABLE_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          seg_in,
  input  logic [NDIG-1:0]     an_in,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [4*NDIG-1:0]   frame_value,
  output logic [NDIG-1:0]     frame_err,
  output logic [NDIG-1:0]     frame_dp,
  output logic                sel_err
);

  localparam int unsigned IDX_W = $clog2(NDIG);

  logic [7:0]                  r_s_seg, r_prev_seg;
  logic [NDIG-1:0]             r_s_an, r_prev_an;
  logic [CNT_W-1:0]            r_cnt;
  logic [NDIG-1:0]             r_seen, r_werr, r_wdp;
  logic [NDIG-1:0][NIB_W-1:0]  r_wval;
  frame_state_e                r_state;

  logic                        w_changed, w_fire, w_any, w_multi, w_cap, w_sel_evt;
  logic                        w_full, w_xfer, w_dec_err;
  logic [IDX_W-1:0]            w_idx;
  logic [NIB_W-1:0]            w_dec_val;
  logic [NDIG-1:0]             w_seen_nx, w_werr_nx, w_wdp_nx;
  logic [NDIG-1:0][NIB_W-1:0]  w_wval_nx;

  // Input registers and stability counter; reset to all ones so the first live change restarts counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_seg    <= '1;
      r_s_an     <= '1;
      r_prev_seg <= '1;
      r_prev_an  <= '1;
      r_cnt      <= '0;
    end else begin
      r_s_seg    <= seg_in;
      r_s_an     <= an_in;
      r_prev_seg <= r_s_seg;
      r_prev_an  <= r_s_an;
      if (w_changed)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(STABLE_CYC))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_changed = ({r_s_an, r_s_seg} != {r_prev_an, r_prev_seg});
  assign w_fire    = !w_changed && (r_cnt == CNT_W'(STABLE_CYC - 1));

  // Digit-select qualification: index of the low bit, plus any/multiple-low flags
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!r_s_an[i]) begin
        w_multi = w_multi | w_any;
        w_any   = 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign w_cap     = w_fire && w_any && !w_multi;
  assign w_sel_evt = w_fire && w_multi;

  seg_pattern_dec u_dec (
    .i_pat   (r_s_seg[SEG_W-1:0]),
    .o_val_c (w_dec_val),
    .o_err_c (w_dec_err)
  );

  // Working-register next state, including a capture landing this cycle
  always_comb begin
    w_wval_nx = r_wval;
    w_werr_nx = r_werr;
    w_wdp_nx  = r_wdp;
    w_seen_nx = r_seen;
    if (w_cap) begin
      w_wval_nx[w_idx] = w_dec_val;
      w_werr_nx[w_idx] = w_dec_err;
      w_wdp_nx[w_idx]  = ~r_s_seg[SEG_DP_BIT];
      w_seen_nx[w_idx] = 1'b1;
    end
  end

  assign w_full = &w_seen_nx;
  assign w_xfer = frame_valid && frame_ready;

  // Working registers and frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wval      <= '0;
      r_werr      <= '0;
      r_wdp       <= '0;
      r_seen      <= '0;
      r_state     <= ST_COLLECT;
      frame_valid <= 1'b0;
      frame_value <= '0;
      frame_err   <= '0;
      frame_dp    <= '0;
      sel_err     <= 1'b0;
    end else begin
      r_wval <= w_wval_nx;
      r_werr <= w_werr_nx;
      r_wdp  <= w_wdp_nx;
      r_seen <= w_seen_nx;
      if (w_sel_evt)
        sel_err <= 1'b1;
      else if (w_xfer)
        sel_err <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_full) begin
            frame_value <= w_wval_nx;
            frame_err   <= w_werr_nx;
            frame_dp    <= w_wdp_nx;
            r_seen      <= '0;
            frame_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_xfer) begin
            if (w_full) begin
              frame_value <= w_wval_nx;
              frame_err   <= w_werr_nx;
              frame_dp    <= w_wdp_nx;
              r_seen      <= '0;
            end else begin
              frame_valid <= 1'b0;
              r_state     <= ST_COLLECT;
            end
          end
        end
        default: begin
          frame_valid <= 1'b0;
          r_state     <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's nibble-to-7-segment encoder. Monitors a multiplexed, active-low 7-segment display bus (segment lines plus digit-select lines).
- Waits for each digit's pattern to be stable, decodes it back to a 4-bit value, and assembles one value per digit position.
- Delivers a complete frame over a valid/ready handshake.
- Used for display loopback self-test and bench-side scoreboarding of the display path.

Parameters:
- NDIG, 8, number of multiplexed digit positions (2..16).
- STABLE_CYC, 4, consecutive identical registered samples required before capture (>=2).
- CNT_W, $clog2(STABLE_CYC+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  8  active-low segments. Bit 7 = dp; bits 6..0 = a,b,c,d,e,f,g. All inputs are synchronous to clk.
- an_in  in  NDIG  active-low digit selects; one low bit selects that digit.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts frame.
- frame_value  out  4*NDIG  decoded nibbles; digit i occupies [4i+3:4i].
- frame_err  out  NDIG  bit i set if digit i's pattern was not a legal code.
- frame_dp  out  NDIG  bit i set if digit i's dp was lit (seg_in[7]=0).
- sel_err  out  1  sticky: more than one an_in bit was low during a stable interval.

Behaviour:
- Input stage: seg_in and an_in registered once (s_seg, s_an). All decisions use the registered values.
- Stability counter:
  - cnt resets to 0 whenever {s_an,s_seg} differs from the previous cycle's value.
  - Otherwise cnt increments, saturating at STABLE_CYC.
  - A capture fires in the single cycle where cnt goes STABLE_CYC-1 -> STABLE_CYC, so there is exactly one capture per stable interval.
- Capture qualification:
  - s_an has exactly one 0 bit: write working regs w_val[idx], w_err[idx], w_dp[idx] and set seen[idx]. idx is the position of that 0 bit.
  - s_an all ones (blanked): no capture, no error.
  - Two or more 0 bits: no capture; set sel_err.
  - Latency: pins to working register = 1 (input reg) + STABLE_CYC cycles.
- Decode, inverse of the encoder (pattern {a..g} -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F
  - Any other pattern: value 0, err 1.
  - dp = ~seg[7], independent of err.
  - A recapture of the same digit overwrites that digit's working regs.
- Frame FSM, states COLLECT and HOLD:
  - COLLECT: when seen is all ones (including a capture in the current cycle), next cycle copy the working regs to the frame outputs, clear seen, raise frame_valid, and enter HOLD.
  - HOLD: outputs held stable while frame_valid=1 and frame_ready=0. Captures continue into the working regs and seen.
  - Transfer occurs when frame_valid && frame_ready. Next cycle: if seen is all ones, load the new frame and stay in HOLD with frame_valid=1. Otherwise drop frame_valid and return to COLLECT.
  - sel_err clears on a transfer, unless a new multi-select event occurs in the same cycle; set wins.
  - frame_ready while frame_valid=0 is ignored.
- Reset, valid at any point including mid-capture or mid-HOLD:
  - Clears s_seg/s_an to all ones, cnt=0, seen=0, working regs=0.
  - frame_valid=0, frame_value=0, frame_err=0, frame_dp=0, sel_err=0, state COLLECT.
  - A pending frame is discarded.
  - After reset release, the all-ones input reset value means the first live change restarts stability counting.

Decomposition:
- seg_pkg holds:
  - Sixteen 7-bit segment code constants (SEG_0..SEG_F), shared with the encoder.
  - SEG_DP_BIT = 7.
  - Segment-order definition {a,b,c,d,e,f,g} = bits 6..0.
- Sub-module seg_pattern_dec: combinational, 7-bit pattern in -> 4-bit value + err. Reusable by other monitors.
- The top holds the input registers, stability counter, one-hot check/index, working regs and frame FSM.

Test Plan:
- Reset, then drive an_in=8'hFE (digit 0), seg_in=8'h81 held 5 cycles, repeating across all 8 digits with values 0..7 -> frame_valid=1 once. frame_value=32'h76543210, frame_err=0, frame_dp=0.
- Same scan with frame_ready=0 for 40 cycles, then a second scan of A..F,8,9 -> first frame held unchanged until ready. After the transfer cycle, the next frame 32'h98FEDCBA appears with no gap.
- Digit 3 driven with illegal pattern 8'hFF and digit 5 with 8'h00 -> frame_err=8'h08. Digit 3 value 0, digit 5 value 8 with frame_dp bit 5 = 1.
- Glitch: digit 2 pattern held only STABLE_CYC-1 cycles, then changed -> no capture, seen bit 2 stays clear, no frame until digit 2 is stable for 4 cycles.
- an_in=8'hFC held 6 cycles -> sel_err=1, no capture. Sel_err clears the cycle after the next frame transfer. an_in=8'hFF produces no error.
- Assert rst during HOLD with 6 of 8 digits of the next frame already seen -> all outputs zero next cycle. A full new scan is needed for the next frame (stale seen bits are not reused).
